cart_upload_reader: RTL and testbench
=====================================

Name: cart_upload_reader

Overview:
- Serves HPS ioctl upload (core-to-HPS) read requests by fetching bytes from the cartridge RAM and returning them on ioctl_din with an ioctl_wait handshake.
- It is the read-side counterpart of the ioctl download path that fills cartridge RAM; it makes the loaded or patched image dumpable.
- Sits beside hps_io in the emu top. It shares the RAM read port with the console through an external arbiter that gives this block priority while ioctl_upload=1.

Parameters:
- ADDR_W, 15, cartridge RAM address width (32 KiB).
- RAM_LAT, 1, RAM read latency in clocks from ram_rd to valid ram_q; legal range 1..3.
- PAD_BYTE, 8'hFF, value returned for addresses at or beyond cart_size.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_upload  in  1  high for the whole upload transfer
- ioctl_rd  in  1  single-cycle read request strobe
- ioctl_addr  in  25  byte address, sampled with ioctl_rd
- ioctl_din  out  8  returned byte
- ioctl_wait  out  1  high while the requested byte is not yet valid
- cart_size  in  16  loaded image size in bytes; 0 means empty
- ram_addr  out  ADDR_W  RAM read address
- ram_rd  out  1  RAM read strobe, one cycle
- ram_q  in  8  RAM read data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the falling edge of ioctl_upload
- byte_count  out  16  bytes delivered in the current or last upload, saturating at 16'hFFFF
- overrun  out  1  sticky; set when ioctl_rd arrives while busy
- csum  out  16  additive checksum (see Optional Feature)

Behaviour:
Reset (reset_n=0, async):
- All outputs 0, state IDLE, latency counter 0.
- Applies equally mid-transfer; the aborted fetch is lost.

Upload edges (ioctl_upload registered once):
- Rising edge: clear byte_count, overrun and csum.
- Falling edge: done=1 for exactly one cycle. byte_count, overrun and csum hold.

State machine:
- IDLE:
  - ioctl_rd=1 with ioctl_upload=1: latch ioctl_addr.
  - If addr >= cart_size, or addr[24:ADDR_W] != 0: go to PAD.
  - Otherwise go to FETCH.
  - ioctl_rd with ioctl_upload=0: ignored.
- FETCH (1 cycle): ram_addr=latched addr[ADDR_W-1:0], ram_rd=1, ioctl_wait=1. Go to WAITQ and load the counter with RAM_LAT-1.
- WAITQ: ioctl_wait=1. When the counter reaches 0, register ram_q into ioctl_din and go to IDLE. ioctl_wait falls in that same cycle.
- PAD (1 cycle): ioctl_din=PAD_BYTE, ioctl_wait stays 0, go to IDLE.

Latency, with ioctl_rd sampled at cycle 0:
- RAM path: ioctl_wait=1 from cycle 1. ioctl_din is valid and ioctl_wait=0 at cycle RAM_LAT+2.
- Pad path: ioctl_din valid at cycle 1; ioctl_wait never rises.

Other rules:
- ram_rd is asserted only in FETCH. ram_addr holds its last value otherwise.
- byte_count increments by 1 in the cycle ioctl_din is updated (RAM or pad path) and saturates at 16'hFFFF.
- ioctl_rd while busy: the request is dropped, overrun is set, and the transfer in flight continues unaffected.
- ioctl_upload falling while in FETCH or WAITQ: abort to IDLE next cycle. ioctl_wait=0, ioctl_din unchanged, byte not counted.
- cart_size=0: every read takes the pad path.
- Coincident ioctl_rd and ioctl_upload rising edge: clearing is applied first, then the request is accepted normally.

Optional Feature:
- Macro UPLOAD_CSUM_EN.
- Defined: csum += ioctl_din (16-bit wrap, zero-extended byte) each time a byte is delivered, pad bytes included; cleared on upload rising edge and on reset.
- Undefined: csum tied to 16'h0000. Port list unchanged.

Decomposition:
- Package cart_io_pkg holds:
  - state enum {IDLE, FETCH, WAITQ, PAD}
  - PAD_BYTE default
  - IOCTL_ADDR_W=25
  - CSUM_W=16
- One natural sub-module, rd_lat_ctr: loadable down-counter that signals data-ready after RAM_LAT cycles. It is reused by other RAM-read clients.

Test Plan:
- Basic RAM read, RAM_LAT=1: preload RAM[0x0010]=0xA5, cart_size=0x1000, ioctl_rd with addr 0x10 at cycle 0 -> ram_rd=1 at cycle 1; ioctl_wait=1 at cycles 1–2; ioctl_din=0xA5 and wait=0 at cycle 3; byte_count=1.
- Pad path: cart_size=0x0800, read addr 0x0800, then 0x1_0000 -> each returns 0xFF at cycle 1; ram_rd never asserted; wait never high; byte_count=2.
- Overrun: issue a second ioctl_rd at cycle 1 of a RAM read -> first byte returned correctly at cycle 3; overrun=1 and stays 1; byte_count=1. Next upload rising edge clears overrun.
- Abort and done: drop ioctl_upload during WAITQ (RAM_LAT=3) -> IDLE next cycle; wait=0; byte not counted; done pulses exactly once.
- Async reset mid-fetch: reset_n=0 during FETCH -> all outputs 0 immediately (no clock edge needed). After release, a new read completes normally.
- Checksum (UPLOAD_CSUM_EN defined): dump 4 bytes 0xFF, 0x01, 0x80, 0x80 -> csum=0x0200. Undefined: csum=0 throughout.

Source files
------------

// File: rtl/cart_io_pkg.sv
// Shared types and constants for the cartridge ioctl upload read path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cart_io_pkg;

   localparam int         IOCTL_ADDR_W = 25;
   localparam int         CSUM_W       = 16;
   localparam logic [7:0] PAD_BYTE_DEF = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAITQ = 2'd2,
      PAD   = 2'd3
   } state_t;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rd_lat_ctr.sv
// Loadable down-counter flagging when a RAM read result is due.
// Latency: o_ready is high once the loaded value has counted down to zero.
// Backpressure: none; a new load restarts the count at any time.
module rd_lat_ctr #(
   parameter int CNT_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_ready
);

   logic [CNT_W-1:0] r_cnt;

   // Load on request, otherwise count down and rest at zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_ready = (r_cnt == '0);

endmodule

// File: rtl/cart_upload_reader.sv
// Serves HPS ioctl upload reads from cartridge RAM; optional checksum under UPLOAD_CSUM_EN.
// Latency: RAM byte valid RAM_LAT+2 cycles after ioctl_rd; pad byte valid 1 cycle after.
// Backpressure: ioctl_wait held high during a RAM fetch; reads arriving while busy are dropped and flag overrun.
module cart_upload_reader
   import cart_io_pkg::*;
#(
   parameter int         ADDR_W   = 15,
   parameter int         RAM_LAT  = 1,
   parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF
) (
   input  logic                    clk_sys,
   input  logic                    reset_n,
   input  logic                    ioctl_upload,
   input  logic                    ioctl_rd,
   input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
   output logic [7:0]              ioctl_din,
   output logic                    ioctl_wait,
   input  logic [15:0]             cart_size,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic                    ram_rd,
   input  logic [7:0]              ram_q,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             byte_count,
   output logic                    overrun,
   output logic [CSUM_W-1:0]       csum
);

   localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_upload_d;
   logic              w_up_rise;
   logic              w_up_fall;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [7:0]        r_din;
   logic [15:0]       r_count;
   logic [15:0]       w_count_base;
   logic              r_overrun;
   logic              r_done;
   logic              w_accept;
   logic              w_pad_sel;
   logic              w_abort;
   logic              w_lat_rdy;
   logic              w_ram_done;
   logic              w_pad_go;
   logic              w_deliver;
   logic [7:0]        w_din_nxt;
   logic              w_busy;
   logic              w_wait;
   logic              w_ram_rd;

   assign w_up_rise  = ioctl_upload & ~r_upload_d;
   assign w_up_fall  = ~ioctl_upload & r_upload_d;
   assign w_accept   = (r_state == IDLE) & ioctl_rd & ioctl_upload;
   // Out of the loaded image or beyond the RAM window: answer with the pad byte
   assign w_pad_sel  = (ioctl_addr >= {{(IOCTL_ADDR_W-16){1'b0}}, cart_size}) |
                       (|ioctl_addr[IOCTL_ADDR_W-1:ADDR_W]);
   assign w_abort    = ((r_state == FETCH) | (r_state == WAITQ)) & ~ioctl_upload;
   assign w_ram_done = (r_state == WAITQ) & w_lat_rdy & ~w_abort;
   assign w_pad_go   = w_accept & w_pad_sel;
   assign w_deliver  = w_ram_done | w_pad_go;
   assign w_din_nxt  = w_ram_done ? ram_q : PAD_BYTE;
   // An upload start clears the counters before this cycle's delivery is counted
   assign w_count_base = w_up_rise ? 16'h0000 : r_count;

   rd_lat_ctr #(
      .CNT_W (2)
   ) u_lat_ctr (
      .i_clk      (clk_sys),
      .i_rst_n    (reset_n),
      .i_load     (r_state == FETCH),
      .i_load_val (LAT_LOAD),
      .o_ready    (w_lat_rdy)
   );

   // State register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; an upload drop mid-fetch abandons the byte
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_pad_sel ? PAD : FETCH;
            end
         end
         FETCH: begin
            w_state_nxt = w_abort ? IDLE : WAITQ;
         end
         WAITQ: begin
            if (w_abort || w_lat_rdy) begin
               w_state_nxt = IDLE;
            end
         end
         PAD: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State-decoded outputs
   always_comb begin
      w_busy   = (r_state != IDLE);
      w_wait   = (r_state == FETCH) | (r_state == WAITQ);
      w_ram_rd = (r_state == FETCH);
   end

   // Upload edge tracking, returned data, counters and sticky overrun
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_upload_d <= 1'b0;
         r_done     <= 1'b0;
         r_ram_addr <= '0;
         r_din      <= 8'h00;
         r_count    <= 16'h0000;
         r_overrun  <= 1'b0;
      end else begin
         r_upload_d <= ioctl_upload;
         r_done     <= w_up_fall;
         if (w_accept && !w_pad_sel) begin
            r_ram_addr <= ioctl_addr[ADDR_W-1:0];
         end
         if (w_deliver) begin
            r_din <= w_din_nxt;
         end
         r_count   <= w_deliver ? sat_inc16(w_count_base) : w_count_base;
         r_overrun <= (r_overrun & ~w_up_rise) | (ioctl_rd & w_busy);
      end
   end

`ifdef UPLOAD_CSUM_EN
   logic [CSUM_W-1:0] r_csum;
   logic [CSUM_W-1:0] w_csum_base;

   assign w_csum_base = w_up_rise ? '0 : r_csum;

   // Running 16-bit sum of every delivered byte, pad bytes included
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_csum <= '0;
      end else if (w_deliver) begin
         r_csum <= w_csum_base + {{(CSUM_W-8){1'b0}}, w_din_nxt};
      end else begin
         r_csum <= w_csum_base;
      end
   end

   assign csum = r_csum;
`else
   assign csum = '0;
`endif

   assign ioctl_din  = r_din;
   assign ioctl_wait = w_wait;
   assign ram_addr   = r_ram_addr;
   assign ram_rd     = w_ram_rd;
   assign busy       = w_busy;
   assign done       = r_done;
   assign byte_count = r_count;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_cart_upload_reader.sv
// Directed bench for cart_upload_reader: one instance at RAM_LAT=1, one at RAM_LAT=3.
// Latency: inputs driven 1ns after the rising edge, outputs checked in the same window.
// Backpressure: bench RAM models return data exactly RAM_LAT cycles after ram_rd, zero otherwise.
module tb_cart_upload_reader;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [15:0] cart_size;

   logic [7:0]  din1, din3;
   logic        wait1, wait3;
   logic [14:0] ram_addr1, ram_addr3;
   logic        ram_rd1, ram_rd3;
   logic [7:0]  ram_q1, ram_q3;
   logic        busy1, busy3;
   logic        done1, done3;
   logic [15:0] cnt1, cnt3;
   logic        ovr1, ovr3;
   logic [15:0] csum1, csum3;

   logic [7:0]  mem [0:32767];
   logic [7:0]  p1_0;
   logic [7:0]  p3_0, p3_1, p3_2;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk_sys = ~clk_sys;

   cart_upload_reader #(.ADDR_W(15), .RAM_LAT(1), .PAD_BYTE(8'hFF)) u1 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_din(din1), .ioctl_wait(wait1), .cart_size(cart_size),
      .ram_addr(ram_addr1), .ram_rd(ram_rd1), .ram_q(ram_q1), .busy(busy1), .done(done1),
      .byte_count(cnt1), .overrun(ovr1), .csum(csum1)
   );

   cart_upload_reader #(.ADDR_W(15), .RAM_LAT(3), .PAD_BYTE(8'hFF)) u3 (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_din(din3), .ioctl_wait(wait3), .cart_size(cart_size),
      .ram_addr(ram_addr3), .ram_rd(ram_rd3), .ram_q(ram_q3), .busy(busy3), .done(done3),
      .byte_count(cnt3), .overrun(ovr3), .csum(csum3)
   );

   // RAM models: data only appears RAM_LAT cycles after a strobe
   always @(posedge clk_sys) begin
      p1_0 <= ram_rd1 ? mem[ram_addr1] : 8'h00;
      p3_0 <= ram_rd3 ? mem[ram_addr3] : 8'h00;
      p3_1 <= p3_0;
      p3_2 <= p3_1;
   end
   assign ram_q1 = p1_0;
   assign ram_q3 = p3_2;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_upload();
      ioctl_upload = 1'b0;
      tick();
      tick();
      ioctl_upload = 1'b1;
      tick();
   endtask

   task automatic do_read(input logic [24:0] a);
      ioctl_rd   = 1'b1;
      ioctl_addr = a;
      tick();
      ioctl_rd = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) tick();
      total_cnt++; if (din1 !== 8'h00) $display("FAIL reset_din: got %h exp 00", din1); else pass_cnt++;
      total_cnt++; if (wait1 !== 1'b0) $display("FAIL reset_wait: got %b exp 0", wait1); else pass_cnt++;
      total_cnt++; if (ram_rd1 !== 1'b0 || ram_addr1 !== 15'h0) $display("FAIL reset_ram: got rd %b addr %h exp 0 0", ram_rd1, ram_addr1); else pass_cnt++;
      total_cnt++; if (busy1 !== 1'b0 || done1 !== 1'b0 || ovr1 !== 1'b0) $display("FAIL reset_flags: got busy %b done %b ovr %b exp 0 0 0", busy1, done1, ovr1); else pass_cnt++;
      total_cnt++; if (cnt1 !== 16'h0 || csum1 !== 16'h0) $display("FAIL reset_counts: got cnt %h csum %h exp 0 0", cnt1, csum1); else pass_cnt++;
      reset_n = 1'b1;
   endtask

   task automatic test_basic_read();
      ioctl_upload = 1'b1;
      cart_size    = 16'h1000;
      tick();
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h10;
      tick();
      ioctl_rd = 1'b0;
      total_cnt++; if (ram_rd1 !== 1'b1 || ram_addr1 !== 15'h10) $display("FAIL basic_c1_ram: got rd %b addr %h exp 1 0010", ram_rd1, ram_addr1); else pass_cnt++;
      total_cnt++; if (wait1 !== 1'b1) $display("FAIL basic_c1_wait: got %b exp 1", wait1); else pass_cnt++;
      tick();
      total_cnt++; if (wait1 !== 1'b1 || ram_rd1 !== 1'b0) $display("FAIL basic_c2: got wait %b rd %b exp 1 0", wait1, ram_rd1); else pass_cnt++;
      tick();
      total_cnt++; if (din1 !== 8'hA5 || wait1 !== 1'b0) $display("FAIL basic_c3: got din %h wait %b exp a5 0", din1, wait1); else pass_cnt++;
      total_cnt++; if (cnt1 !== 16'd1 || busy1 !== 1'b0) $display("FAIL basic_c3_cnt: got cnt %0d busy %b exp 1 0", cnt1, busy1); else pass_cnt++;
      tick();
      total_cnt++; if (wait3 !== 1'b1) $display("FAIL lat3_c4_wait: got %b exp 1", wait3); else pass_cnt++;
      tick();
      total_cnt++; if (din3 !== 8'hA5 || wait3 !== 1'b0 || cnt3 !== 16'd1) $display("FAIL lat3_c5: got din %h wait %b cnt %0d exp a5 0 1", din3, wait3, cnt3); else pass_cnt++;
      tick();
   endtask

   task automatic test_pad();
      cart_size = 16'h0800;
      start_upload();
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h0800;
      tick();
      ioctl_rd = 1'b0;
      total_cnt++; if (din1 !== 8'hFF || wait1 !== 1'b0 || ram_rd1 !== 1'b0) $display("FAIL pad1_c1: got din %h wait %b rd %b exp ff 0 0", din1, wait1, ram_rd1); else pass_cnt++;
      total_cnt++; if (busy1 !== 1'b1) $display("FAIL pad1_busy: got %b exp 1", busy1); else pass_cnt++;
      tick();
      total_cnt++; if (busy1 !== 1'b0 || wait1 !== 1'b0) $display("FAIL pad1_c2: got busy %b wait %b exp 0 0", busy1, wait1); else pass_cnt++;
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h1_0000;
      tick();
      ioctl_rd = 1'b0;
      total_cnt++; if (din1 !== 8'hFF || wait1 !== 1'b0 || ram_rd1 !== 1'b0 || din3 !== 8'hFF) $display("FAIL pad2_c1: got din %h wait %b rd %b din3 %h exp ff 0 0 ff", din1, wait1, ram_rd1, din3); else pass_cnt++;
      tick();
      total_cnt++; if (cnt1 !== 16'd2 || cnt3 !== 16'd2) $display("FAIL pad_count: got %0d/%0d exp 2/2", cnt1, cnt3); else pass_cnt++;
      // Empty image: even address 0 pads
      cart_size  = 16'h0000;
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h0;
      tick();
      ioctl_rd = 1'b0;
      total_cnt++; if (ram_rd1 !== 1'b0 || wait1 !== 1'b0 || din1 !== 8'hFF) $display("FAIL pad_empty: got rd %b wait %b din %h exp 0 0 ff", ram_rd1, wait1, din1); else pass_cnt++;
      tick();
      total_cnt++; if (cnt1 !== 16'd3) $display("FAIL pad_empty_cnt: got %0d exp 3", cnt1); else pass_cnt++;
   endtask

   task automatic test_overrun();
      cart_size = 16'h1000;
      start_upload();
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h20;
      tick();
      ioctl_addr = 25'h30;
      total_cnt++; if (ram_addr1 !== 15'h20) $display("FAIL ovr_c1_addr: got %h exp 0020", ram_addr1); else pass_cnt++;
      tick();
      ioctl_rd = 1'b0;
      total_cnt++; if (ovr1 !== 1'b1 || ovr3 !== 1'b1) $display("FAIL ovr_set: got %b/%b exp 1/1", ovr1, ovr3); else pass_cnt++;
      tick();
      total_cnt++; if (din1 !== 8'h3C || cnt1 !== 16'd1) $display("FAIL ovr_c3: got din %h cnt %0d exp 3c 1", din1, cnt1); else pass_cnt++;
      repeat (3) tick();
      total_cnt++; if (ovr1 !== 1'b1 || busy1 !== 1'b0 || ram_addr1 !== 15'h20 || cnt1 !== 16'd1) $display("FAIL ovr_hold: got ovr %b busy %b addr %h cnt %0d exp 1 0 0020 1", ovr1, busy1, ram_addr1, cnt1); else pass_cnt++;
      total_cnt++; if (din3 !== 8'h3C || cnt3 !== 16'd1) $display("FAIL ovr_lat3: got din %h cnt %0d exp 3c 1", din3, cnt3); else pass_cnt++;
      start_upload();
      total_cnt++; if (ovr1 !== 1'b0 || cnt1 !== 16'd0) $display("FAIL ovr_clear: got ovr %b cnt %0d exp 0 0", ovr1, cnt1); else pass_cnt++;
   endtask

   task automatic test_abort_done();
      int dn;
      dn = 0;
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h40;
      tick();
      ioctl_rd = 1'b0;
      tick();
      total_cnt++; if (wait3 !== 1'b1 || busy3 !== 1'b1) $display("FAIL abort_pre: got wait %b busy %b exp 1 1", wait3, busy3); else pass_cnt++;
      ioctl_upload = 1'b0;
      tick();
      total_cnt++; if (busy3 !== 1'b0 || wait3 !== 1'b0) $display("FAIL abort_idle: got busy %b wait %b exp 0 0", busy3, wait3); else pass_cnt++;
      total_cnt++; if (din3 !== 8'h3C || cnt3 !== 16'd0) $display("FAIL abort_nocount: got din %h cnt %0d exp 3c 0", din3, cnt3); else pass_cnt++;
      total_cnt++; if (done3 !== 1'b1) $display("FAIL done_pulse: got %b exp 1", done3); else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         if (done3 === 1'b1) dn++;
         tick();
      end
      total_cnt++; if (dn != 1) $display("FAIL done_once: got %0d pulses exp 1", dn); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      cart_size    = 16'h1000;
      ioctl_upload = 1'b1;
      tick();
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h10;
      tick();
      ioctl_rd = 1'b0;
      total_cnt++; if (ram_rd1 !== 1'b1) $display("FAIL arst_pre: got rd %b exp 1", ram_rd1); else pass_cnt++;
      #2;
      reset_n = 1'b0;
      #1;
      total_cnt++; if (ram_rd1 !== 1'b0 || wait1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL arst_async: got rd %b wait %b busy %b exp 0 0 0", ram_rd1, wait1, busy1); else pass_cnt++;
      total_cnt++; if (din1 !== 8'h00 || ram_addr1 !== 15'h0 || cnt1 !== 16'h0) $display("FAIL arst_regs: got din %h addr %h cnt %0d exp 00 0000 0", din1, ram_addr1, cnt1); else pass_cnt++;
      tick();
      reset_n = 1'b1;
      // First cycle after release also sees the upload rise: clear then accept
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h10;
      tick();
      ioctl_rd = 1'b0;
      tick();
      tick();
      total_cnt++; if (din1 !== 8'hA5 || wait1 !== 1'b0 || cnt1 !== 16'd1) $display("FAIL arst_after: got din %h wait %b cnt %0d exp a5 0 1", din1, wait1, cnt1); else pass_cnt++;
      repeat (3) tick();
   endtask

   task automatic test_csum();
      logic [15:0] exp_sum;
`ifdef UPLOAD_CSUM_EN
      exp_sum = 16'h0200;
`else
      exp_sum = 16'h0000;
`endif
      cart_size = 16'h0200;
      start_upload();
      total_cnt++; if (csum1 !== 16'h0000) $display("FAIL csum_clear: got %h exp 0000", csum1); else pass_cnt++;
      do_read(25'h300);
      do_read(25'h100);
      do_read(25'h101);
      do_read(25'h102);
      total_cnt++; if (cnt1 !== 16'd4 || cnt3 !== 16'd4) $display("FAIL csum_cnt: got %0d/%0d exp 4/4", cnt1, cnt3); else pass_cnt++;
      total_cnt++; if (csum1 !== exp_sum || csum3 !== exp_sum) $display("FAIL csum_value: got %h/%h exp %h", csum1, csum3, exp_sum); else pass_cnt++;
      total_cnt++; if (din1 !== 8'h80) $display("FAIL csum_last_din: got %h exp 80", din1); else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[16'h0010] = 8'hA5;
      mem[16'h0020] = 8'h3C;
      mem[16'h0030] = 8'hC3;
      mem[16'h0040] = 8'h77;
      mem[16'h0100] = 8'h01;
      mem[16'h0101] = 8'h80;
      mem[16'h0102] = 8'h80;
      reset_n      = 1'b0;
      ioctl_upload = 1'b0;
      ioctl_rd     = 1'b0;
      ioctl_addr   = 25'h0;
      cart_size    = 16'h0;
      test_reset();
      test_basic_read();
      test_pad();
      test_overrun();
      test_abort_done();
      test_async_reset();
      test_csum();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
